// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm/countdown clock: switch codes, BCD digit limits,
// cursor digit indices, setter FSM encoding and per-digit step helpers.
package alarm_clock_pkg;

    localparam logic [1:0] SW_TIMER_MODE = 2'b10;
    localparam logic [1:0] SW_SET_MODE   = 2'b11;

    localparam logic [3:0] MAX_HOUR_LEFT  = 4'd9;
    localparam logic [3:0] MAX_HOUR_RIGHT = 4'd9;
    localparam logic [3:0] MAX_MIN_LEFT   = 4'd5;
    localparam logic [3:0] MAX_MIN_RIGHT  = 4'd9;
    localparam logic [3:0] MAX_SEC_LEFT   = 4'd5;
    localparam logic [3:0] MAX_SEC_RIGHT  = 4'd9;

    localparam logic [2:0] DIGIT_SEC_RIGHT  = 3'd0;
    localparam logic [2:0] DIGIT_SEC_LEFT   = 3'd1;
    localparam logic [2:0] DIGIT_MIN_RIGHT  = 3'd2;
    localparam logic [2:0] DIGIT_MIN_LEFT   = 3'd3;
    localparam logic [2:0] DIGIT_HOUR_RIGHT = 3'd4;
    localparam logic [2:0] DIGIT_HOUR_LEFT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } setter_state_e;

    function automatic logic [3:0] digit_max(input logic [2:0] idx);
        case (idx)
            DIGIT_SEC_RIGHT:  digit_max = MAX_SEC_RIGHT;
            DIGIT_SEC_LEFT:   digit_max = MAX_SEC_LEFT;
            DIGIT_MIN_RIGHT:  digit_max = MAX_MIN_RIGHT;
            DIGIT_MIN_LEFT:   digit_max = MAX_MIN_LEFT;
            DIGIT_HOUR_RIGHT: digit_max = MAX_HOUR_RIGHT;
            default:          digit_max = MAX_HOUR_LEFT;
        endcase
    endfunction

    // Steps one BCD digit up or down with wrap at its own limit; neighbours never carry.
    function automatic logic [23:0] step_digit(input logic [23:0] value,
                                               input logic [2:0]  idx,
                                               input logic        up);
        logic [4:0] base;
        logic [3:0] d;
        logic [3:0] lim;
        step_digit = value;
        if (idx <= DIGIT_HOUR_LEFT) begin
            base = {idx, 2'b00};
            d    = value[base +: 4];
            lim  = digit_max(idx);
            if (up) begin
                d = (d >= lim) ? 4'd0 : d + 4'd1;
            end else begin
                d = (d == 4'd0) ? lim : d - 4'd1;
            end
            step_digit[base +: 4] = d;
        end
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for a debounced button level: registers the level and
// pulses for one cycle when the level goes 0 -> 1.
module rise_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/timer_setter.sv
// Button-driven editor for the six-digit BCD HH:MM:SS countdown preset.
// Optional auto-repeat of held increase/decrease is built when TIMER_SETTER_REPEAT_EN is defined.
module timer_setter
    import alarm_clock_pkg::*;
#(
    parameter logic [1:0]  SET_MODE      = SW_SET_MODE,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  switch_state,
    input  logic        button_left,
    input  logic        button_right,
    input  logic        button_increase,
    input  logic        button_decrease,
    input  logic        button_confirm,
    output logic [23:0] intended_set_timer,
    output logic        timer_propagate,
    output logic [2:0]  cursor,
    output logic        editing
);

    // Strobe contract: timer_propagate is high for exactly one clk, and
    // intended_set_timer holds the committed value from that edge onward.

    setter_state_e state, state_next;
    logic [23:0]   working, working_next;
    logic [23:0]   intended_next;
    logic [2:0]    cursor_next;
    logic          prop_next;

    logic left_p, right_p, inc_p, dec_p, conf_p;
    logic mode_set;
    logic rpt_fire;
    logic rpt_up;

    rise_edge_detect u_left  (.clk(clk), .rst_n(rst_n), .level(button_left),     .pulse(left_p));
    rise_edge_detect u_right (.clk(clk), .rst_n(rst_n), .level(button_right),    .pulse(right_p));
    rise_edge_detect u_inc   (.clk(clk), .rst_n(rst_n), .level(button_increase), .pulse(inc_p));
    rise_edge_detect u_dec   (.clk(clk), .rst_n(rst_n), .level(button_decrease), .pulse(dec_p));
    rise_edge_detect u_conf  (.clk(clk), .rst_n(rst_n), .level(button_confirm),  .pulse(conf_p));

    assign mode_set = (switch_state == SET_MODE);
    assign editing  = (state == ST_EDIT);

`ifdef TIMER_SETTER_REPEAT_EN
    localparam logic [25:0] DELAY_M1  = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] PERIOD_M1 = 26'(REPEAT_PERIOD - 1);

    logic [25:0] rpt_cnt;
    logic        rpt_armed;
    logic        rpt_in_period;
    logic        rpt_held;
    logic        any_edge;
    logic        step_edge;

    assign any_edge  = left_p | right_p | inc_p | dec_p | conf_p;
    assign step_edge = (state == ST_EDIT) && mode_set && !conf_p && (inc_p || dec_p);
    assign rpt_held  = rpt_up ? button_increase : button_decrease;
    assign rpt_fire  = rpt_armed && (state == ST_EDIT) && mode_set && !any_edge && rpt_held &&
                       (rpt_cnt == (rpt_in_period ? PERIOD_M1 : DELAY_M1));

    // A fresh inc/dec edge (re)starts the delay; anything else that interrupts cancels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt       <= '0;
            rpt_armed     <= 1'b0;
            rpt_in_period <= 1'b0;
            rpt_up        <= 1'b1;
        end else if (step_edge) begin
            rpt_cnt       <= '0;
            rpt_armed     <= 1'b1;
            rpt_in_period <= 1'b0;
            rpt_up        <= inc_p;
        end else if (any_edge || state != ST_EDIT || !mode_set || !rpt_held) begin
            rpt_armed     <= 1'b0;
        end else if (rpt_armed) begin
            if (rpt_fire) begin
                rpt_cnt       <= '0;
                rpt_in_period <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 26'd1;
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire = 1'b0;
    assign rpt_up   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            working            <= '0;
            cursor             <= '0;
            intended_set_timer <= '0;
            timer_propagate    <= 1'b0;
        end else begin
            state              <= state_next;
            working            <= working_next;
            cursor             <= cursor_next;
            intended_set_timer <= intended_next;
            timer_propagate    <= prop_next;
        end
    end

    always_comb begin
        state_next    = state;
        working_next  = working;
        cursor_next   = cursor;
        intended_next = intended_set_timer;
        prop_next     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mode_set) begin
                    working_next = intended_set_timer;
                    cursor_next  = DIGIT_SEC_RIGHT;
                    state_next   = ST_EDIT;
                end
            end
            ST_EDIT: begin
                // One action per cycle; lower-priority edges in the same cycle are dropped.
                if (!mode_set) begin
                    state_next = ST_IDLE;
                end else if (conf_p) begin
                    if (working != 24'd0) begin
                        state_next = ST_COMMIT;
                    end
                end else if (inc_p) begin
                    working_next = step_digit(working, cursor, 1'b1);
                end else if (dec_p) begin
                    working_next = step_digit(working, cursor, 1'b0);
                end else if (left_p) begin
                    cursor_next = (cursor == DIGIT_HOUR_LEFT) ? DIGIT_SEC_RIGHT : cursor + 3'd1;
                end else if (right_p) begin
                    cursor_next = (cursor == DIGIT_SEC_RIGHT) ? DIGIT_HOUR_LEFT : cursor - 3'd1;
                end else if (rpt_fire) begin
                    working_next = step_digit(working, cursor, rpt_up);
                end
            end
            ST_COMMIT: begin
                intended_next = working;
                prop_next     = 1'b1;
                state_next    = mode_set ? ST_EDIT : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
